// File: rtl/vfpu_issue_arb.sv
// vfpu_issue_arb -- two-requester round-robin issue arbiter for the VFPU.
//
// Accepts one operation per cycle from requester 0 or 1, registers it onto
// the VFPU issue port, and tracks the issuing requester in an in-order tag
// FIFO. Results return in issue order and are routed back combinationally
// to the requester whose tag sits at the head of the FIFO.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   req_vld/req_ins/req_a/b/c   per-requester operation request (i = 0,1)
//   req_rdy                     per-requester accept strobe (combinational)
//   op_vld, vfpu_ins, operand_* registered issue to the VFPU datapath
//   res_rdy, res                in-order VFPU result
//   rsp_vld, rsp_data           per-requester result strobe, shared data
//   busy                        operations outstanding
//   err_unexp                   sticky: result arrived with nothing outstanding

// Per-requester ready/response decode.
module vfpu_issue_lane #(
  parameter logic ID = 1'b0
) (
  input  logic accept,
  input  logic gnt_id,
  input  logic pop,
  input  logic head_id,
  output logic req_rdy,
  output logic rsp_vld
);
  assign req_rdy = accept && (gnt_id == ID);
  assign rsp_vld = pop && (head_id == ID);
endmodule

module vfpu_issue_arb #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_vld,
  input  logic [1:0][5:0]  req_ins,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  input  logic [1:0][31:0] req_c,
  output logic [1:0]       req_rdy,
  output logic             op_vld,
  output logic [5:0]       vfpu_ins,
  output logic [31:0]      operand_a,
  output logic [31:0]      operand_b,
  output logic [31:0]      operand_c,
  input  logic             res_rdy,
  input  logic [31:0]      res,
  output logic [1:0]       rsp_vld,
  output logic [31:0]      rsp_data,
  output logic             busy,
  output logic             err_unexp
);
  localparam int NUM_REQ = 2;
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [5:0]  ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } op_t;

  logic          rr;
  logic          gnt_id;
  logic          accept;
  logic          pop;
  logic          empty;
  logic          head_id;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          tag_q [DEPTH];
  op_t           op_q;

  // Pointer holder wins when it is requesting; otherwise the other one,
  // so a lone requester is always granted.
  always_comb begin
    gnt_id = rr;
    if (!req_vld[rr]) gnt_id = ~rr;
  end

  assign empty   = (cnt == '0);
  assign head_id = tag_q[rd_ptr];
  // rst gating keeps the strobes low for the whole reset window, not just
  // after the flops clear.
  assign pop     = res_rdy && !empty && !rst;
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign accept  = (|req_vld) && ((cnt < CW'(DEPTH)) || pop) && !rst;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    vfpu_issue_lane #(.ID(1'(i))) u_lane (
      .accept  (accept),
      .gnt_id  (gnt_id),
      .pop     (pop),
      .head_id (head_id),
      .req_rdy (req_rdy[i]),
      .rsp_vld (rsp_vld[i])
    );
  end

  assign rsp_data = res;
  assign busy     = (cnt != '0);

  // Tag storage needs no reset: pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (accept) tag_q[wr_ptr] <= gnt_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr        <= 1'b0;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      err_unexp <= 1'b0;
      op_vld    <= 1'b0;
      op_q      <= '0;
    end else begin
      op_vld <= accept;
      if (accept) begin
        rr     <= ~gnt_id;
        wr_ptr <= wr_ptr + PW'(1);
        op_q   <= '{ins: req_ins[gnt_id], a: req_a[gnt_id],
                    b: req_b[gnt_id], c: req_c[gnt_id]};
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (res_rdy && empty) err_unexp <= 1'b1;
    end
  end

  assign vfpu_ins  = op_q.ins;
  assign operand_a = op_q.a;
  assign operand_b = op_q.b;
  assign operand_c = op_q.c;
endmodule

// File: tb/tb_vfpu_issue_arb.sv
module tb_vfpu_issue_arb;
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_vld;
  logic [1:0][5:0]  req_ins;
  logic [1:0][31:0] req_a, req_b, req_c;
  logic [1:0]       req_rdy;
  logic             op_vld;
  logic [5:0]       vfpu_ins;
  logic [31:0]      operand_a, operand_b, operand_c;
  logic             res_rdy;
  logic [31:0]      res;
  logic [1:0]       rsp_vld;
  logic [31:0]      rsp_data;
  logic             busy, err_unexp;

  int nerr = 0;
  int nchk = 0;

  vfpu_issue_arb #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_ins(req_ins),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_rdy(req_rdy),
    .op_vld(op_vld), .vfpu_ins(vfpu_ins), .operand_a(operand_a),
    .operand_b(operand_b), .operand_c(operand_c), .res_rdy(res_rdy),
    .res(res), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .busy(busy),
    .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pedge();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_vld = '0; req_ins = '0; req_a = '0; req_b = '0; req_c = '0;
    res_rdy = 1'b0; res = '0;
    #1;
    chk("rst_op_vld", 32'(op_vld), 0);
    chk("rst_req_rdy", 32'(req_rdy), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_unexp), 0);
    chk("rst_ins", 32'(vfpu_ins), 0);
    @(negedge clk); rst = 1'b0;

    // Single op from requester 0
    req_vld = 2'b01; req_ins[0] = 6'h01; req_a[0] = 32'h3F800000;
    req_b[0] = 32'h11111111; req_c[0] = 32'h22222222;
    #1 chk("t1_rdy", 32'(req_rdy), 32'h1);
    pedge();
    chk("t1_op_vld", 32'(op_vld), 1);
    chk("t1_ins", 32'(vfpu_ins), 32'h01);
    chk("t1_a", operand_a, 32'h3F800000);
    chk("t1_b", operand_b, 32'h11111111);
    chk("t1_c", operand_c, 32'h22222222);
    chk("t1_busy", 32'(busy), 1);
    req_vld = 2'b00;
    pedge();
    chk("t1_op_vld_low", 32'(op_vld), 0);
    chk("t1_ins_hold", 32'(vfpu_ins), 32'h01);
    chk("t1_a_hold", operand_a, 32'h3F800000);
    @(negedge clk); res_rdy = 1'b1; res = 32'h40000000;
    #1;
    chk("t1_rsp_vld", 32'(rsp_vld), 32'h1);
    chk("t1_rsp_data", rsp_data, 32'h40000000);
    pedge(); res_rdy = 1'b0;
    chk("t1_idle", 32'(busy), 0);

    // Re-reset so the round-robin pointer starts at 0
    @(negedge clk); rst = 1'b1; #2 rst = 1'b0;

    // Both requesters valid for 6 cycles, each result returned next cycle
    req_ins[0] = 6'h02; req_ins[1] = 6'h03;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_vld = 2'b11; res_rdy = (i > 0); res = 32'hA0000000 + 32'(i);
      #1;
      chk("t2_rdy", 32'(req_rdy), (i % 2) ? 32'h2 : 32'h1);
      if (i > 0) begin
        chk("t2_rsp_vld", 32'(rsp_vld), ((i - 1) % 2) ? 32'h2 : 32'h1);
        chk("t2_rsp_data", rsp_data, 32'hA0000000 + 32'(i));
      end
      pedge();
      chk("t2_op_vld", 32'(op_vld), 1);
      chk("t2_ins", 32'(vfpu_ins), (i % 2) ? 32'h03 : 32'h02);
    end
    @(negedge clk); req_vld = 2'b00; res_rdy = 1'b1;
    #1 chk("t2_last_rsp", 32'(rsp_vld), 32'h2);
    pedge(); res_rdy = 1'b0;
    chk("t2_idle", 32'(busy), 0);

    // Fill to DEPTH, stall, then accept against a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req_vld = 2'b01;
      #1 chk("t3_fill_rdy", 32'(req_rdy), 32'h1);
    end
    @(negedge clk); #1;
    chk("t3_stall", 32'(req_rdy), 32'h0);
    res_rdy = 1'b1;
    #1;
    chk("t3_pop_accept", 32'(req_rdy), 32'h1);
    chk("t3_pop_rsp", 32'(rsp_vld), 32'h1);
    pedge(); res_rdy = 1'b0;
    chk("t3_busy", 32'(busy), 1);
    @(negedge clk); #1;
    chk("t3_still_full", 32'(req_rdy), 32'h0);
    req_vld = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); res_rdy = 1'b1;
      #1 chk("t3_drain_rsp", 32'(rsp_vld), 32'h1);
    end
    pedge(); res_rdy = 1'b0;
    chk("t3_drained", 32'(busy), 0);

    // Unexpected result with nothing outstanding
    @(negedge clk); res_rdy = 1'b1;
    #1 chk("t4_no_rsp", 32'(rsp_vld), 32'h0);
    pedge(); res_rdy = 1'b0;
    chk("t4_err", 32'(err_unexp), 1);
    chk("t4_cnt0", 32'(busy), 0);
    pedge();
    chk("t4_err_held", 32'(err_unexp), 1);

    // Asynchronous reset with 3 ops outstanding
    req_ins[0] = 6'h05; req_a[0] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req_vld = 2'b01;
      #1 chk("t5_rdy", 32'(req_rdy), 32'h1);
    end
    pedge();
    chk("t5_busy", 32'(busy), 1);
    res_rdy = 1'b1; rst = 1'b1;
    #1;
    chk("t5_rst_op_vld", 32'(op_vld), 0);
    chk("t5_rst_rdy", 32'(req_rdy), 0);
    chk("t5_rst_rsp", 32'(rsp_vld), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_err", 32'(err_unexp), 0);
    chk("t5_rst_ins", 32'(vfpu_ins), 0);
    chk("t5_rst_a", operand_a, 0);
    @(negedge clk); rst = 1'b0; req_vld = 2'b00; res_rdy = 1'b1;
    #1 chk("t5_post_rsp", 32'(rsp_vld), 32'h0);
    pedge(); res_rdy = 1'b0;
    chk("t5_post_err", 32'(err_unexp), 1);
    chk("t5_post_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/vfpu_issue_arb.md
VFPU_ISSUE_ARB -- requirements
Module: vfpu_issue_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4: maximum outstanding VFPU operations and depth of the in-order tag FIFO (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all flops on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req_vld[i]  input  1  requester i (i=0,1) has an operation pending.
REQ-005 SHALL have ports req_ins[i]  input  6  instruction encoding, one of 16 VFPU instructions.
REQ-006 SHALL have ports req_a[i], req_b[i], req_c[i]  input  32  single-precision operands.
REQ-007 SHALL have ports req_rdy[i]  output  1  operation accepted this cycle.
REQ-008 SHALL have port op_vld  output  1  issue strobe to the VFPU datapath.
REQ-009 SHALL have ports vfpu_ins  output  6; operand_a, operand_b, operand_c  output  32  the issued operation.
REQ-010 SHALL have port res_rdy  input  1  VFPU result valid, returned in issue order.
REQ-011 SHALL have port res  input  32  VFPU result.
REQ-012 SHALL have ports rsp_vld[i]  output  1  result for requester i.
REQ-013 SHALL have port rsp_data  output  32  result data, shared by both requesters.
REQ-014 SHALL have port busy  output  1  high while outstanding count is nonzero.
REQ-015 SHALL have port err_unexp  output  1  sticky flag: res_rdy seen with the tag FIFO empty.

Function
REQ-016 SHALL accept an operation when req_vld[i] is high, requester i holds the grant, and the outstanding count is below DEPTH; req_rdy[i] is combinational from these terms.
REQ-017 SHALL arbitrate round-robin: priority pointer rr starts at 0 and moves to the requester after the one granted, on every acceptance only.
REQ-018 SHALL grant to at most one requester per cycle; with one requester active, that requester receives the grant regardless of rr.
REQ-019 SHALL register the accepted operation: op_vld, vfpu_ins and operand_a/b/c appear one cycle after acceptance; op_vld is high for exactly one cycle per acceptance.
REQ-020 SHALL hold vfpu_ins and the operand outputs at their last values when op_vld is low.
REQ-021 SHALL push the granted requester id into the tag FIFO on acceptance and pop it when res_rdy is high.
REQ-022 SHALL drive rsp_vld[popped id] high and rsp_data=res in the same cycle as res_rdy (combinational pass-through, zero latency).
REQ-023 SHALL keep a 0..DEPTH outstanding count: +1 on accept, -1 on pop; accept and pop in the same cycle leave it unchanged.
REQ-024 SHALL still accept in a cycle where count==DEPTH and res_rdy is high, because the pop frees a slot combinationally.
REQ-025 SHALL, when res_rdy arrives with the FIFO empty, drive no rsp_vld, leave the count at 0, and set err_unexp, which holds until reset.
REQ-026 SHALL have no backpressure on responses; requesters sink rsp_vld unconditionally.
REQ-027 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-028 SHALL, while rst is high, force op_vld=0, req_rdy=0, rsp_vld=0, busy=0, err_unexp=0, count=0, rr=0, FIFO pointers=0, vfpu_ins=0, and operands=0.
REQ-029 SHALL discard all outstanding tags on reset mid-operation; a res_rdy arriving after reset release sets err_unexp.

Verification
REQ-030 SHALL cover: req_vld[0] only, ins=6'h01, a=32'h3F800000 -> req_rdy[0] in the same cycle, op_vld with matching fields one cycle later; res_rdy with res=32'h40000000 -> rsp_vld[0]=1 and rsp_data=32'h40000000.
REQ-031 SHALL cover: both requesters held valid for 6 cycles with an immediate-return model -> grants 0,1,0,1,0,1 and responses routed in the same order.
REQ-032 SHALL cover: 5 back-to-back requests with no res_rdy (DEPTH=4) -> 4 accepted, the 5th stalls; one res_rdy in the stall cycle -> 5th accepted that cycle and count stays 4.
REQ-033 SHALL cover: res_rdy pulse with nothing outstanding -> no rsp_vld, err_unexp=1 and held.
REQ-034 SHALL cover: rst asserted with 3 ops outstanding -> all outputs per REQ-028 immediately (asynchronous); the subsequent res_rdy sets err_unexp.
